// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA job sequencer and the RSA core wrapper:
// sequencer state encoding and default parameter values.
package rsa_pkg;

    typedef enum logic [2:0] {
        ST_KEYWAIT = 3'd0,
        ST_IDLE    = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RUN     = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam int DEF_WIDTH             = 32;
    localparam int DEF_LOAD_CYCLES       = 2;
    localparam int DEF_TIMEOUT_CYCLES    = 1 << 20;
    localparam int DEF_KEY_SETTLE_CYCLES = 4096;

endpackage

// File: rtl/rsa_watchdog.sv
// Loadable down-counter. expired is set only once a value has been loaded and
// has counted down to zero, so a cleared counter never reports expiry.
module rsa_watchdog #(
    parameter int CW = 21
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          enable,
    output logic          loaded,
    output logic          expired
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count  <= '0;
            loaded <= 1'b0;
        end else if (load) begin
            count  <= load_value;
            loaded <= 1'b1;
        end else if (enable && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = loaded && (count == '0);

endmodule

// File: rtl/rsa_block_sequencer.sv
// Job sequencer around the RSA core: accepts one message per job, parks and
// restarts the exponentiator, bounds each job with a watchdog, returns the result.
module rsa_block_sequencer
    import rsa_pkg::*;
#(
    parameter int WIDTH             = DEF_WIDTH,
    parameter int KEY_SETTLE_CYCLES = DEF_KEY_SETTLE_CYCLES,
    parameter int LOAD_CYCLES       = DEF_LOAD_CYCLES,
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH-1:0]   s_data,
    input  logic               s_mode,
    output logic [WIDTH-1:0]   core_msg_in,
    output logic               core_encrypt_decrypt,
    output logic               core_reset1,
    input  logic [2*WIDTH-1:0] core_msg_out,
    input  logic               core_finish,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [2*WIDTH-1:0] m_data,
    output logic               m_timeout,
    output state_t             dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; ready/valid are decoded from state only, never from the peer.

    localparam int WD_MAX = (KEY_SETTLE_CYCLES > TIMEOUT_CYCLES) ? KEY_SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(WD_MAX + 1);
    localparam int LCW    = $clog2(LOAD_CYCLES + 1);

    state_t          state, state_n;
    logic [LCW-1:0]  load_cnt;
    logic            first_run;
    logic            wd_clear, wd_load, wd_enable, wd_loaded, wd_expired;
    logic [CW-1:0]   wd_value;
    logic            run_finish;

    rsa_watchdog #(.CW(CW)) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .clear      (wd_clear),
        .load       (wd_load),
        .load_value (wd_value),
        .enable     (wd_enable),
        .loaded     (wd_loaded),
        .expired    (wd_expired)
    );

    // The first RUN cycle masks a finish left over from the previous job.
    assign run_finish = core_finish && !first_run;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_KEYWAIT;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        wd_clear  = 1'b0;
        wd_load   = 1'b0;
        wd_value  = '0;
        wd_enable = 1'b0;
        unique case (state)
            ST_KEYWAIT: begin
                // The loading cycle is itself one of the settle cycles.
                if (wd_expired) begin
                    state_n = ST_IDLE;
                end else if (!wd_loaded) begin
                    wd_load  = 1'b1;
                    wd_value = CW'(KEY_SETTLE_CYCLES - 2);
                end else begin
                    wd_enable = 1'b1;
                end
            end
            ST_IDLE: begin
                wd_clear = 1'b1;
                if (s_valid) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_cnt == LCW'(LOAD_CYCLES - 1)) begin
                    state_n  = ST_RUN;
                    wd_load  = 1'b1;
                    wd_value = CW'(TIMEOUT_CYCLES - 1);
                end
            end
            ST_RUN: begin
                wd_enable = 1'b1;
                if (run_finish || wd_expired) state_n = ST_HOLD;
            end
            ST_HOLD: begin
                if (m_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_KEYWAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_msg_in          <= '0;
            core_encrypt_decrypt <= 1'b0;
            m_data               <= '0;
            m_timeout            <= 1'b0;
            load_cnt             <= '0;
            first_run            <= 1'b0;
        end else begin
            if (state == ST_IDLE && s_valid) begin
                core_msg_in          <= s_data;
                core_encrypt_decrypt <= s_mode;
            end
            load_cnt  <= (state == ST_LOAD) ? load_cnt + 1'b1 : '0;
            first_run <= (state == ST_LOAD);
            if (state == ST_RUN) begin
                if (run_finish) begin
                    m_data    <= core_msg_out;
                    m_timeout <= 1'b0;
                end else if (wd_expired) begin
                    m_data    <= '0;
                    m_timeout <= 1'b1;
                end
            end
        end
    end

    assign s_ready     = (state == ST_IDLE);
    assign m_valid     = (state == ST_HOLD);
    assign core_reset1 = (state != ST_RUN);
    assign dbg_state   = state;

endmodule

// File: tb/tb_rsa_block_sequencer.sv
// Bench for rsa_block_sequencer with a behavioural RSA core (n=3233, e=17,
// d=2753) and a scoreboard monitor on the result stream.
module tb_rsa_block_sequencer;
    import rsa_pkg::*;

    localparam int W      = 32;
    localparam int KEY    = 16;
    localparam int LOADC  = 2;
    localparam int TMO    = 100;
    localparam int R_FIN  = 40;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [W-1:0]   s_data = '0;
    logic           s_mode = 1'b0;
    logic [W-1:0]   core_msg_in;
    logic           core_encrypt_decrypt;
    logic           core_reset1;
    logic [2*W-1:0] core_msg_out;
    logic           core_finish;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [2*W-1:0] m_data;
    logic           m_timeout;
    state_t         dbg_state;

    int checks = 0;
    int errors = 0;
    logic [2*W:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    rsa_block_sequencer #(
        .WIDTH(W), .KEY_SETTLE_CYCLES(KEY), .LOAD_CYCLES(LOADC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_mode(s_mode),
        .core_msg_in(core_msg_in), .core_encrypt_decrypt(core_encrypt_decrypt),
        .core_reset1(core_reset1), .core_msg_out(core_msg_out), .core_finish(core_finish),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_timeout(m_timeout),
        .dbg_state(dbg_state)
    );

    // ---------------- behavioural core ----------------
    bit             hang = 1'b0;
    bit             stale_mode = 1'b0;
    bit             ran = 1'b0;
    int             run_cnt = 0;
    logic [2*W-1:0] res = '0;

    function automatic logic [2*W-1:0] modpow(input longint b, input longint e);
        longint r = 1;
        longint x = b % 3233;
        longint k = e;
        while (k > 0) begin
            if (k[0]) r = (r * x) % 3233;
            x = (x * x) % 3233;
            k = k >>> 1;
        end
        return (2*W)'(r);
    endfunction

    always @(posedge clk) begin
        if (core_reset1) begin
            run_cnt <= 0;
            ran     <= 1'b0;
            res     <= modpow(longint'(core_msg_in), core_encrypt_decrypt ? 64'd17 : 64'd2753);
        end else begin
            run_cnt <= run_cnt + 1;
            ran     <= 1'b1;
        end
    end

    assign core_finish  = hang ? 1'b0 : ((stale_mode && !ran) || (run_cnt >= R_FIN - 1));
    assign core_msg_out = (stale_mode && !ran) ? 64'hDEAD_BEEF : res;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && m_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got timeout=%0b data=%0d, none expected", m_timeout, m_data);
            end else begin
                if ({m_timeout, m_data} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL result: got timeout=%0b data=%0d, expected timeout=%0b data=%0d",
                             m_timeout, m_data, exp_q[0][2*W], exp_q[0][2*W-1:0]);
                end
                if (m_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Presents a job and returns once it has been taken (accept edge just passed).
    task automatic send_accept(input logic [W-1:0] d, input logic m);
        bit ok = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = d; s_mode = m;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: s_ready never rose");
        end
    endtask

    // Cycles counted inclusively from the accept cycle to the first m_valid cycle.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 2; n < 400; n++) begin
            @(negedge clk);
            if (m_valid) begin lat = n; break; end
        end
    endtask

    // Posedges after the reset-release edge until s_ready is seen.
    task automatic count_to_ready(output int cnt);
        cnt = -1;
        for (int n = 1; n < 200; n++) begin
            @(posedge clk); #1;
            if (s_ready) begin cnt = n; break; end
        end
    endtask

    // ---------------- stimulus ----------------
    int lat;
    int cnt;

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", m_data, 64'd0);
        check("rst_m_timeout", 64'(m_timeout), 64'd0);
        check("rst_core_msg_in", 64'(core_msg_in), 64'd0);
        check("rst_core_encdec", 64'(core_encrypt_decrypt), 64'd0);
        check("rst_core_reset1", 64'(core_reset1), 64'd1);
        check("rst_state", 64'(dbg_state), 64'(ST_KEYWAIT));

        // 1: key settle delay
        reset = 1'b0;
        count_to_ready(cnt);
        check("key_settle_cycles", 64'(cnt), 64'(KEY));

        // 2: encrypt 65 -> 2790
        m_ready = 1'b1;
        exp_q.push_back({1'b0, 64'd2790});
        send_accept(32'd65, 1'b1);
        check("enc_core_msg_in", 64'(core_msg_in), 64'd65);
        check("enc_core_mode", 64'(core_encrypt_decrypt), 64'd1);
        wait_valid(lat);
        check("enc_latency", 64'(lat), 64'(1 + LOADC + R_FIN + 1));

        // 3: decrypt 2790 -> 65 with a 10-cycle output stall
        @(posedge clk); #1;
        m_ready = 1'b0;
        exp_q.push_back({1'b0, 64'd65});
        send_accept(32'd2790, 1'b0);
        wait_valid(lat);
        check("dec_latency", 64'(lat), 64'(1 + LOADC + R_FIN + 1));
        repeat (10) @(negedge clk);
        check("stall_hold_valid", 64'(m_valid), 64'd1);
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(negedge clk);
        check("no_bypass_s_ready", 64'(s_ready), 64'd0);
        @(posedge clk); #1;
        check("back_to_idle_state", 64'(dbg_state), 64'(ST_IDLE));
        check("back_to_idle_ready", 64'(s_ready), 64'd1);

        // 4: hung core -> timeout after LOAD + TMO RUN cycles
        hang = 1'b1;
        exp_q.push_back({1'b1, 64'd0});
        send_accept(32'd123, 1'b1);
        wait_valid(lat);
        check("timeout_latency", 64'(lat), 64'(1 + LOADC + TMO + 1));
        @(posedge clk); #1;
        hang = 1'b0;

        // 5: stale finish in first RUN cycle is ignored
        stale_mode = 1'b1;
        exp_q.push_back({1'b0, 64'd2790});
        send_accept(32'd65, 1'b1);
        wait_valid(lat);
        check("stale_latency", 64'(lat), 64'(1 + LOADC + R_FIN + 1));
        @(posedge clk); #1;
        stale_mode = 1'b0;

        // 6: reset pulse during RUN drops the job
        send_accept(32'd65, 1'b1);
        repeat (10) @(negedge clk);
        check("mid_reset_in_run", 64'(dbg_state), 64'(ST_RUN));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_reset_state", 64'(dbg_state), 64'(ST_KEYWAIT));
        check("mid_reset_m_valid", 64'(m_valid), 64'd0);
        check("mid_reset_core_reset1", 64'(core_reset1), 64'd1);
        count_to_ready(cnt);
        check("mid_reset_settle", 64'(cnt), 64'(KEY));
        exp_q.push_back({1'b0, 64'd2790});
        send_accept(32'd65, 1'b1);
        wait_valid(lat);
        check("after_reset_latency", 64'(lat), 64'(1 + LOADC + R_FIN + 1));

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
